main_mem_responder: RTL and testbench

Memory-side responder for the core's main-memory interface: it answers the core's address, write-enable and bidirectional data bus at the other end of the pads. It holds a DEPTH x DW data store and captures core writes. For reads it returns registered data and drives the shared bus, with an enforced turnaround so the two bus drivers never overlap. A host preload port with a valid/ready handshake initialises the store before or during a run. The block is used as the board/FPGA-side memory and as the bench memory model.

---
 rtl/main_mem_responder.sv | 115 +++++++++++
 tb/tb_main_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_responder.sv
// main_mem_responder: DEPTH x DW memory behind the core's shared data bus.
// Captures core writes, returns registered read data, and only drives the bus
// after a fixed turnaround following a core write so the two drivers never overlap.
// A host preload port (valid/ready) can fill the store at any time outside writes.
module main_mem_responder #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 16,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] mem_addr,
  input  logic          mem_write_en,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic [AW:0]   load_count,
  output logic          busy_turn
);

  localparam int unsigned CW = $clog2(TURN_CYCLES + 1);
  localparam logic [CW-1:0] TurnInit = CW'(TURN_CYCLES - 1);
  localparam logic [AW:0] CountMax = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StHold, StTurn, StDrive, StWrite} state_e;

  state_e        state_q;
  logic [CW-1:0] turn_cnt_q;
  logic [DW-1:0] store [DEPTH];
  logic          load_fire;

  // Bus is released combinationally the cycle write_en rises: no contention cycle.
  assign bus_oe     = (state_q == StDrive) & ~mem_write_en;
  assign busy_turn  = (state_q == StHold) | (state_q == StTurn);
  // Core writes own the array port; the host must hold its request until accepted.
  assign load_ready = ~rst & (state_q != StHold) & ~mem_write_en;
  assign load_fire  = load_valid & load_ready;

  // Bus ownership FSM with turnaround counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StHold;
      turn_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (mem_write_en) begin
            state_q <= StWrite;
          end else begin
            state_q    <= StTurn;
            turn_cnt_q <= TurnInit;
          end
        end
        StTurn: begin
          if (mem_write_en) begin
            state_q <= StWrite;
          end else if (turn_cnt_q == '0) begin
            state_q <= StDrive;
          end else begin
            turn_cnt_q <= turn_cnt_q - CW'(1);
          end
        end
        StDrive: begin
          if (mem_write_en) begin
            state_q <= StWrite;
          end
        end
        StWrite: begin
          if (!mem_write_en) begin
            state_q    <= StTurn;
            turn_cnt_q <= TurnInit;
          end
        end
        default: state_q <= StHold;
      endcase
    end
  end

  // Storage array: core write has priority over a host preload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else if (mem_write_en) begin
      store[mem_addr] <= bus_in;
    end else if (load_fire) begin
      store[load_addr] <= load_data;
    end
  end

  // Registered read data; holds while the core is writing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_out <= '0;
    end else if (!mem_write_en) begin
      bus_out <= store[mem_addr];
    end
  end

  // Accepted preload counter, saturating at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_count <= '0;
    end else if (load_fire && (load_count != CountMax)) begin
      load_count <= load_count + (AW + 1)'(1);
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Bench for main_mem_responder: default build (TURN_CYCLES=1) plus a TURN_CYCLES=3 build.
// Reads on the default build go through an expected-value queue checked by a monitor.
module tb_main_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_addr;
  logic        mem_write_en;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        bus_oe;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic [8:0]  load_count;
  logic        busy_turn;

  logic [7:0]  w3_addr;
  logic        w3_en;
  logic [15:0] w3_in;
  logic [15:0] bus_out3;
  logic        oe3;
  logic        l3_valid;
  logic        l3_ready;
  logic [7:0]  l3_addr;
  logic [15:0] l3_data;
  logic [8:0]  l3_count;
  logic        busy3;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic rd_tag = 1'b0;
  logic rd_pend = 1'b0;

  always #5 clk = ~clk;

  main_mem_responder dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_write_en(mem_write_en),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .load_valid(load_valid),
    .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
    .load_count(load_count), .busy_turn(busy_turn)
  );

  main_mem_responder #(.TURN_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .mem_addr(w3_addr), .mem_write_en(w3_en),
    .bus_in(w3_in), .bus_out(bus_out3), .bus_oe(oe3), .load_valid(l3_valid),
    .load_ready(l3_ready), .load_addr(l3_addr), .load_data(l3_data),
    .load_count(l3_count), .busy_turn(busy3)
  );

  // Monitor: a tagged read presents its data one cycle later while driving the bus.
  always @(posedge clk) rd_pend <= rd_tag;

  always @(negedge clk) begin
    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected: got %h with nothing queued", bus_out);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (!bus_oe || bus_out !== e) begin
          errors++;
          $display("FAIL read_data: got %h oe=%b, expected %h oe=1", bus_out, bus_oe, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] e);
    mem_addr = a;
    rd_tag = 1'b1;
    exp_q.push_back(e);
    tick();
    rd_tag = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    mem_addr = '0; mem_write_en = 1'b0; bus_in = '0;
    load_valid = 1'b0; load_addr = '0; load_data = '0;
    w3_addr = '0; w3_en = 1'b0; w3_in = '0;
    l3_valid = 1'b0; l3_addr = '0; l3_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle: HOLD, one TURN cycle, then drive
    settle();
    chk("hold_oe", bus_oe, 0);
    chk("hold_busy", busy_turn, 1);
    chk("hold_load_ready", load_ready, 0);
    chk("reset_count", load_count, 0);
    chk("reset_bus_out", bus_out, 0);
    tick();
    settle();
    chk("turn_oe", bus_oe, 0);
    chk("turn_load_ready", load_ready, 1);
    tick();
    settle();
    chk("drive_oe", bus_oe, 1);
    chk("drive_busy", busy_turn, 0);
    chk("drive_bus_out", bus_out, 0);
    tick();

    // Preload then read
    load_valid = 1'b1; load_addr = 8'h10; load_data = 16'hBEEF;
    tick();
    load_addr = 8'hFF; load_data = 16'h1234;
    tick();
    load_valid = 1'b0;
    settle();
    chk("preload_count", load_count, 2);
    tick();
    rd(8'h10, 16'hBEEF);
    rd(8'hFF, 16'h1234);
    settle();
    tick();

    // Write and turnaround
    mem_write_en = 1'b1; mem_addr = 8'h20; bus_in = 16'hA5A5;
    settle();
    chk("oe_release_same_cycle", bus_oe, 0);
    chk("write_load_ready", load_ready, 0);
    tick();
    mem_write_en = 1'b0;
    settle();
    chk("write_fall_oe", bus_oe, 0);
    tick();
    settle();
    chk("turnaround_oe", bus_oe, 0);
    chk("turnaround_busy", busy_turn, 1);
    chk("read_after_write", bus_out, 16'hA5A5);
    rd_tag = 1'b1;
    exp_q.push_back(16'hA5A5);
    tick();
    rd_tag = 1'b0;
    settle();
    chk("drive_after_turn", bus_oe, 1);
    tick();

    // Load vs write collision at 0x30
    load_valid = 1'b1; load_addr = 8'h30; load_data = 16'h2222;
    mem_write_en = 1'b1; mem_addr = 8'h30; bus_in = 16'h1111;
    settle();
    chk("collision_ready", load_ready, 0);
    tick();
    mem_write_en = 1'b0;
    settle();
    chk("collision_ready_after", load_ready, 1);
    chk("collision_count_held", load_count, 2);
    tick();
    load_valid = 1'b0;
    settle();
    chk("collision_write_won", bus_out, 16'h1111);
    chk("collision_count", load_count, 3);
    rd_tag = 1'b1;
    exp_q.push_back(16'h2222);
    tick();
    rd_tag = 1'b0;
    settle();
    tick();

    // Count saturation: 253 more loads reach 256, one extra still writes
    for (int i = 0; i < 253; i++) begin
      load_valid = 1'b1;
      load_addr = 8'(i);
      load_data = 16'(i) ^ 16'h5A5A;
      tick();
    end
    load_valid = 1'b0;
    settle();
    chk("count_full", load_count, 256);
    tick();
    load_valid = 1'b1; load_addr = 8'h40; load_data = 16'h7777;
    tick();
    load_valid = 1'b0;
    settle();
    chk("count_saturated", load_count, 256);
    tick();
    rd(8'h40, 16'h7777);
    rd(8'h05, 16'h5A5F);
    settle();
    tick();

    // Asynchronous reset mid-operation with a load pending
    load_valid = 1'b1; load_addr = 8'h60; load_data = 16'h9999;
    settle();
    chk("oe_before_reset", bus_oe, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_oe", bus_oe, 0);
    chk("async_load_ready", load_ready, 0);
    chk("async_count", load_count, 0);
    chk("async_busy", busy_turn, 1);
    load_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    rd(8'h10, 16'h0000);
    rd(8'h40, 16'h0000);
    settle();
    tick();

    // TURN_CYCLES=3 build: 4-cycle write burst then read
    settle();
    chk("t3_drive_oe", oe3, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      w3_en = 1'b1; w3_addr = 8'h50 + 8'(k); w3_in = 16'hC3C0 + 16'(k);
      settle();
      chk("t3_burst_oe", oe3, 0);
      tick();
    end
    w3_en = 1'b0; w3_addr = 8'h53;
    settle();
    chk("t3_fall_oe", oe3, 0);
    chk("t3_fall_busy", busy3, 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t3_turn_oe", oe3, 0);
      chk("t3_turn_busy", busy3, 1);
      tick();
    end
    settle();
    chk("t3_drive_after", oe3, 1);
    chk("t3_read", bus_out3, 16'hC3C3);
    tick();

    // Re-raise write_en during TURN
    w3_en = 1'b1; w3_addr = 8'h54; w3_in = 16'h1357;
    tick();
    w3_en = 1'b0;
    tick();
    settle();
    chk("t3_reenter_turn", busy3, 1);
    tick();
    w3_en = 1'b1; w3_addr = 8'h55; w3_in = 16'h2468;
    settle();
    chk("t3_reraise_oe", oe3, 0);
    tick();
    settle();
    chk("t3_back_to_write", busy3, 0);
    chk("t3_write_oe", oe3, 0);
    tick();
    w3_en = 1'b0;
    settle();
    tick();
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t3_turn2_oe", oe3, 0);
      tick();
    end
    settle();
    chk("t3_drive2", oe3, 1);
    chk("t3_read2", bus_out3, 16'h2468);

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
